// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and write squash.
// Optional performance counters (stall_cnt, bubble_cnt) enabled by defining PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_wen,
    input  logic [ADDR_W-1:0] in_waddr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wen,
    output logic [ADDR_W-1:0] out_waddr,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              wen;
        logic [ADDR_W-1:0] waddr;
    } entry_t;

    // Encoding is {skid_v, main_v}; 2'b10 cannot be reached.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b11
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    entry_t r_main;
    entry_t r_skid;
    entry_t w_main_nxt;
    entry_t w_skid_nxt;
    entry_t w_in_entry;
    logic   w_main_v;
    logic   w_skid_v;
    logic   w_acc;
    logic   w_take;

    assign w_main_v   = r_state[0];
    assign w_skid_v   = r_state[1];
    assign w_in_entry = {in_data, in_wen, in_waddr};

    // Ready comes straight from a flop so upstream never sees out_ready combinationally.
    assign in_ready  = !w_skid_v;
    assign w_acc     = in_valid & in_ready;
    assign w_take    = w_main_v & out_ready;

    assign out_valid = w_main_v;
    assign out_data  = r_main.data;
    assign out_waddr = r_main.waddr;
    assign out_wen   = r_main.wen & w_main_v;
    assign occupancy = 2'(w_main_v) + 2'(w_skid_v);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            // Data may stay stale; clearing the valid bits is enough to squash writes.
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = w_in_entry;
                    end
                end
                S_ONE: begin
                    if (w_acc && w_take) begin
                        w_main_nxt  = w_in_entry;
                    end else if (w_acc) begin
                        w_state_nxt = S_FULL;
                        w_skid_nxt  = w_in_entry;
                    end else if (w_take) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_take) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_stall;
    logic             w_bubble;

    assign w_stall    = in_valid & !in_ready;
    assign w_bubble   = flush & (w_main_v | w_skid_v);
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

    // Saturating counters, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with a FIFO scoreboard of accepted entries.
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W = 48;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              w;
        logic [ADDR_W-1:0] a;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_wen;
    logic [ADDR_W-1:0] in_waddr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_wen;
    logic [ADDR_W-1:0] out_waddr;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
    int                exp_stall;
    int                exp_bubble;
`endif

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_wen    (in_wen),
        .in_waddr  (in_waddr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_wen   (out_wen),
        .out_waddr (out_waddr),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_SKID_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs with the scoreboard at negedge, update the model.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic we,
                        input logic [ADDR_W-1:0] wa, input logic ordy, input logic fl);
        logic acc;
        logic take;
        ent_t e;
        in_valid  = v;
        in_data   = d;
        in_wen    = we;
        in_waddr  = wa;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(q[0].d));
            chk("out_wen", 64'(out_wen), 64'(q[0].w));
            chk("out_waddr", 64'(out_waddr), 64'(q[0].a));
        end else begin
            chk("out_wen_idle", 64'(out_wen), 64'(0));
        end
`ifdef PIPE_STAGE_SKID_PERF_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(exp_bubble));
        if (v && q.size() == 2 && exp_stall < (2**CNT_W - 1)) exp_stall++;
        if (fl && q.size() > 0 && exp_bubble < (2**CNT_W - 1)) exp_bubble++;
`endif
        acc  = v && (q.size() < 2);
        take = (q.size() > 0) && ordy;
        if (take) void'(q.pop_front());
        if (acc && !fl) begin
            e.d = d;
            e.w = we;
            e.a = wa;
            q.push_back(e);
        end
        if (fl) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, 1'b0, '0, ordy, 1'b0);
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic ordy);
        step(1'b1, d, 1'b0, '0, ordy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_wen    = 1'b0;
        in_waddr  = '0;
        out_ready = 1'b0;
`ifdef PIPE_STAGE_SKID_PERF_EN
        exp_stall  = 0;
        exp_bubble = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_occupancy", 64'(occupancy), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset while FULL, asserted between clock edges.
        send(48'hA, 1'b0);
        send(48'hB, 1'b0);
        idle(1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_occupancy", 64'(occupancy), 64'(0));
        chk("midrst_out_data", 64'(out_data), 64'(0));
        chk("midrst_out_wen", 64'(out_wen), 64'(0));
        q.delete();
`ifdef PIPE_STAGE_SKID_PERF_EN
        exp_stall  = 0;
        exp_bubble = 0;
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming: one entry per cycle, occupancy held at 1.
        for (int i = 1; i <= 8; i++) send(48'(i), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure into the skid buffer, then drain in order.
        send(48'h11, 1'b0);
        send(48'h22, 1'b0);
        send(48'h33, 1'b0);
        send(48'h33, 1'b0);
        send(48'h33, 1'b1);
        send(48'h33, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush while FULL with a concurrent input: nothing survives, writes squashed.
        step(1'b1, 48'h55, 1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b1, 48'h66, 1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b1, 48'h44, 1'b1, 4'd5, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush in ONE with accept and take in the same cycle.
        step(1'b1, 48'h77, 1'b1, 4'd9, 1'b0, 1'b0);
        step(1'b1, 48'h88, 1'b1, 4'd3, 1'b1, 1'b1);
        idle(1'b1);

        // Take while FULL with a waiting input: skid moves up, input held off one cycle.
        send(48'hA, 1'b0);
        send(48'hB, 1'b0);
        send(48'hC, 1'b1);
        send(48'hC, 1'b1);
        idle(1'b1);
        idle(1'b1);

`ifdef PIPE_STAGE_SKID_PERF_EN
        // Three stalled cycles while FULL, then one flush of held entries.
        send(48'hD, 1'b0);
        send(48'hE, 1'b0);
        send(48'hF, 1'b0);
        send(48'hF, 1'b0);
        send(48'hF, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
